// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, error codes, sync marker.
package instr_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StChk,
    StDone
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_ADDR = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler: collects little-endian bytes into a 32-bit word and
// keeps a running XOR of every data byte seen since the last clear.
module loader_word_asm (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word,
  output logic [7:0]  chk
);

  logic [1:0]  idx_q;
  logic [23:0] shift_q;
  logic [7:0]  chk_q;

  // The 4th byte completes the word combinationally so the top can register it directly.
  assign word_done = byte_en && (idx_q == 2'd3);
  assign word      = {byte_in, shift_q};
  assign chk       = chk_q;

  // Byte index, lower three bytes of the word and running checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
      chk_q   <= 8'd0;
    end else if (clear) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
      chk_q   <= 8'd0;
    end else if (byte_en) begin
      idx_q <= idx_q + 2'd1;
      chk_q <= chk_q ^ byte_in;
      if (idx_q != 2'd3) begin
        shift_q[8*idx_q +: 8] <= byte_in;
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Framed byte-stream loader for the instruction memory write port. Holds the core
// in reset while an image loads and releases it after a packet with a good checksum.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic              cpu_hold
);

  localparam int unsigned GapW = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [1:0]        hdr_idx_q, hdr_idx_d;
  logic [7:0]        start_lo_q, start_lo_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        err_q, err_d;
  logic              hold_q, hold_d;
  logic [GapW-1:0]   gap_q, gap_d;

  logic        accept;
  logic        asm_clear, asm_en, word_done;
  logic [31:0] word;
  logic [7:0]  chk;
  logic [15:0] start_full, cnt_full;
  logic [31:0] gap_inc;
  logic        timeout;

  assign in_ready   = !reset && (state_q != StDone);
  assign accept     = in_valid && in_ready;
  assign start_full = {in_data, start_lo_q};
  assign cnt_full   = {in_data, cnt_q[7:0]};
  assign gap_inc    = 32'(gap_q) + 32'd1;
  // A byte in the same cycle wins over the timeout.
  assign timeout    = !accept && (state_q inside {StHdr, StData, StChk}) &&
                      (gap_inc == TIMEOUT_CYC);

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err_code  = err_q;
  assign cpu_hold  = hold_q;

  loader_word_asm u_word_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .byte_en   (asm_en),
    .byte_in   (in_data),
    .word_done (word_done),
    .word      (word),
    .chk       (chk)
  );

  // Next-state: packet parsing, write generation, checksum verdict and idle timeout.
  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    start_lo_d  = start_lo_q;
    cnt_d       = cnt_q;
    next_addr_d = next_addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    hold_d      = hold_q;
    asm_clear   = 1'b0;
    asm_en      = 1'b0;
    gap_d       = (accept || state_q == StIdle) ? '0 : gap_inc[GapW-1:0];

    unique case (state_q)
      StIdle: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d   = StHdr;
          hdr_idx_d = 2'd0;
          err_d     = ERR_NONE;
          hold_d    = 1'b1;
          cnt_d     = 16'd0;
          asm_clear = 1'b1;
        end
      end
      StHdr: begin
        if (accept) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          unique case (hdr_idx_q)
            2'd0: start_lo_d = in_data;
            2'd1: begin
              if ((start_full >> ADDR_W) != 16'd0) begin
                err_d   = ERR_ADDR;
                state_d = StIdle;
              end else begin
                next_addr_d = start_full[ADDR_W-1:0];
              end
            end
            2'd2: cnt_d = {8'h00, in_data};
            2'd3: begin
              cnt_d   = cnt_full;
              state_d = (cnt_full != 16'd0) ? StData : StChk;
            end
          endcase
        end
      end
      StData: begin
        if (accept) begin
          asm_en = 1'b1;
          if (word_done) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = next_addr_q;
            mem_wdata_d = word;
            next_addr_d = next_addr_q + 1'b1;
            cnt_d       = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              state_d = StChk;
            end
          end
        end
      end
      StChk: begin
        if (accept) begin
          if (in_data == chk) begin
            state_d = StDone;
            hold_d  = 1'b0;
          end else begin
            err_d   = ERR_CHK;
            state_d = StIdle;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      err_d   = ERR_TMO;
      state_d = StIdle;
    end
  end

  // State and output registers; reset aborts any packet and holds the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      hdr_idx_q   <= 2'd0;
      start_lo_q  <= 8'd0;
      cnt_q       <= 16'd0;
      next_addr_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      err_q       <= ERR_NONE;
      hold_q      <= 1'b1;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      start_lo_q  <= start_lo_d;
      cnt_q       <= cnt_d;
      next_addr_q <= next_addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
    end
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side counterpart of the IF-stage instruction memory: receives a framed byte stream (UART/debug host) and programs the instruction memory array through its word-indexed write port.
- Holds the core in reset while a program image is loading, then releases it after a packet with a good checksum.
- Sits between the host byte source and the instruction memory write port; the memory read side is unchanged.

Parameters:
- ADDR_W, 10, word-index width (memory depth 2^ADDR_W = 1024 words).
- TIMEOUT_CYC, 100000, maximum idle clocks between bytes inside a packet before abort.
- SYNC_BYTE, 8'hA5, packet start marker.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- in_data  in  8  host byte.
- in_valid  in  1  byte valid; a byte is accepted when in_valid && in_ready.
- in_ready  out  1  loader can accept a byte.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_W  word index (0 = byte address 0x0, 1 = 0x4, ...).
- mem_wdata  out  32  instruction word.
- busy  out  1  packet in progress (any state other than IDLE).
- done  out  1  one-cycle pulse: packet complete and checksum good.
- err_code  out  2  0 none, 1 checksum, 2 timeout, 3 bad address; sticky.
- cpu_hold  out  1  core reset request.

Behaviour:
- Reset (async): state IDLE; mem_we=0, mem_addr=0, mem_wdata=0, done=0, err_code=0, cpu_hold=1, counters cleared. in_ready=0 while reset is high.
- Packet format: SYNC, START_LO, START_HI, CNT_LO, CNT_HI, then CNT words of 4 bytes each (little-endian, LSB first), then CHK. CHK is the XOR of all data bytes; CHK is 0x00 when CNT=0.
- States and transitions:
  - IDLE -> HDR on an accepted SYNC_BYTE. Non-sync bytes are discarded.
  - HDR accepts 4 bytes. After START_HI, if the 16-bit start has any bit at position >= ADDR_W set: err_code=3, return to IDLE, no writes.
  - HDR -> DATA if CNT != 0, else HDR -> CHK.
  - DATA assembles bytes into a 32-bit word.
  - CHK receives the checksum byte.
  - DONE lasts 1 cycle, then returns to IDLE.
- in_ready = !reset && state != DONE. One byte per cycle is sustainable.
- Accepting SYNC in IDLE: clears err_code, sets cpu_hold=1, clears the checksum accumulator and the byte/word counters.
- Writes:
  - mem_we pulses in the cycle after the 4th byte of a word is accepted; mem_addr and mem_wdata are valid in that same cycle.
  - The first write goes to START. Each later write goes to the previous address + 1 (mod 2^ADDR_W), so 0x3FF wraps to 0x000.
  - mem_addr and mem_wdata hold their last value when mem_we=0.
- Word counter: 16-bit, counts down. DATA -> CHK after the 4th byte of the last word.
- Checksum byte accepted:
  - Match: DONE; done=1 next cycle; cpu_hold=0 next cycle.
  - Mismatch: err_code=1, go to IDLE, cpu_hold stays 1. Words already written are not rolled back.
- Timeout: a gap counter resets on every accepted byte and increments on every other cycle in a non-IDLE state. On reaching TIMEOUT_CYC: err_code=2, go to IDLE, cpu_hold stays 1, and any partial word is dropped.
- Reset mid-packet: abort immediately with all outputs at reset values. A partial word is never written.
- Simultaneous events: the timeout and a byte acceptance in the same cycle resolve in favour of the byte. DONE ignores in_valid.

Decomposition:
- Shared package (instr_mem_pkg): state encoding (IDLE, HDR, DATA, CHK, DONE), err_code constants (ERR_NONE, ERR_CHK, ERR_TMO, ERR_ADDR), SYNC_BYTE default.
- One natural sub-module: loader_word_asm (byte-to-word shifter, 2-bit byte index, running XOR); FSM, counters and timeout stay in the top.

Test Plan:
- Single word: bytes A5 00 00 01 00 78 56 34 12 08 -> one mem_we with mem_addr=0, mem_wdata=0x12345678; done=1 one cycle after the 08 byte; cpu_hold goes 1->0; err_code=0.
- Zero count: A5 03 00 00 00 00 -> no mem_we; done pulse; cpu_hold=0.
- Wrap: start 0x03FF, CNT=2, words 0x00000013 and 0x00100093 with correct CHK -> writes at 0x3FF then 0x000.
- Bad checksum: the single-word packet with CHK=0x09 -> word written at addr 0; err_code=1; no done; cpu_hold=1. A following good packet clears err_code at its SYNC.
- Bad address / noise: 11 22 A5 00 04 ... -> the 11 and 22 bytes are ignored; err_code=3 after START_HI; no mem_we; state back to IDLE.
- Timeout/reset (TIMEOUT_CYC=16): stall 16 cycles after 2 data bytes -> err_code=2, no write. A separate run asserts reset mid-word -> all outputs return to reset values and no mem_we occurs.
